ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, e.g. 0xED (set LEDs) or 0xFF (reset).
- It is the transmit-direction partner of keyboard_PS2 and shares the same ps2_clk/ps2_dat pins through open-drain pad logic at the top level.
- Sequence: inhibits the bus, issues a request-to-send, shifts out the frame on device-generated clocks, checks the device ACK, and reports success or error.

Parameters:
- INHIBIT_CYCLES, 6000, cycles ps2_clk is held low before the request-to-send (120 us at 50 MHz, spec minimum 100 us).
- START_TIMEOUT, 750000, max cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 10000, max cycles between consecutive device falling edges after the first (200 us).

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous).
- ps2_dat_in  input  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  output  1  1 = pull ps2_clk low; 0 = release (high-Z).
- ps2_dat_oe  output  1  1 = pull ps2_dat low; 0 = release.
- tx_data  input  8  byte to send; sampled only on accepted tx_start.
- tx_start  input  1  send request, single-cycle pulse.
- tx_busy  output  1  transfer in progress. Top level uses it to gate keyboard_PS2 dat_ready.
- tx_done  output  1  1-cycle pulse: frame sent and ACK received.
- tx_error  output  1  1-cycle pulse: missing ACK or timeout.

Behaviour:
- Reset: all outputs 0 (both lines released, not busy, no pulses). State IDLE, counters cleared. Reset mid-transfer releases both lines on the next clock edge; no done/error pulse is generated.
- Inputs pass through 2-flop synchronizers. Falling edge = previous synced level 1 and current synced level 0. Total latency from pin edge to detection is at most 3 clocks.
- Accept rule: tx_start is accepted only when tx_busy=0. tx_start while busy is ignored and the in-flight byte is not disturbed.
- On accept, latch tx_data and parity = ~^tx_data (odd parity). tx_busy=1 from the next cycle.
- IDLE: both oe=0. On accept -> INHIBIT.
- INHIBIT:
  - clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - dat_oe=1 asserted in the final inhibit cycle (start bit), so data is low before clock is released.
  - -> REQ.
- REQ:
  - clk_oe=0, dat_oe=1.
  - Wait for the first falling edge; on it, drive bit0 (dat_oe = ~bit) -> SHIFT with bit index 1.
  - If START_TIMEOUT cycles elapse without an edge -> ERROR.
- SHIFT:
  - On falling edges 2..8, drive bits 1..7, LSB first.
  - Edge 9: drive parity.
  - Edge 10: stop bit, dat_oe=0 (released) -> ACK.
  - The output changes within 3 clocks of each pin falling edge, while the device holds clock low.
- ACK: on the next (11th) falling edge, sample synced data.
  - 0 -> WAIT_IDLE.
  - 1 -> ERROR.
- WAIT_IDLE: wait until synced clock=1 and data=1 simultaneously, then -> DONE.
- DONE: tx_done=1 for one cycle, tx_busy=0 in that same cycle, -> IDLE. A tx_start in this cycle is accepted.
- ERROR: both oe=0, tx_error=1 for one cycle, tx_busy=0 in that cycle, -> IDLE.
- Bit timeout: applies in SHIFT, ACK and WAIT_IDLE. The timeout counter is cleared on every falling edge, or on entering the state. Reaching BIT_TIMEOUT -> ERROR.
- Exclusivity: tx_done and tx_error are never both 1. There is exactly one pulse per accepted start, unless reset intervenes.
- Counter widths are sized by $clog2 of the largest parameter. No wrap-around is possible before the timeout fires.

Test Plan:
- Use INHIBIT_CYCLES=20, START_TIMEOUT=500, BIT_TIMEOUT=200, with a bus-functional device model clocking at 40-cycle half-periods.
- Send 0xED with the model ACKing:
  - clk_oe high for exactly 20 cycles, dat_oe high in the last of them.
  - Model captures start=0, data LSB-first 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - tx_done pulses once after the lines idle; tx_error stays 0.
- Parity coverage, bytes 0x00, 0x01, 0xFF: model-captured parity 1, 0, 1 respectively; all complete with tx_done.
- Model never ACKs (data stays high at the 11th edge): tx_error pulses one cycle, both oe=0, tx_busy=0, no tx_done.
- Model never clocks after the request: tx_error exactly 500 cycles after clock release, dat_oe returns to 0.
- Model stops clocking after edge 4: tx_error 200 cycles after the 4th edge.
- Pulse tx_start with 0x55 during a 0xED transfer: still sends 0xED, exactly one tx_done.
- Assert reset during SHIFT: the next cycle has clk_oe=dat_oe=tx_busy=0, no pulses. A new tx_start afterward completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit, request-to-send, device-clocked shift-out, ACK check and done/error reporting.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_P = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic             dat_low, dat_low_n;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             load;

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic fall;

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            dat_low  <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            dat_low  <= dat_low_n;
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            if (load) begin
                data_q   <= tx_data;
                parity_q <= ~^tx_data;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bit_idx_n = bit_idx;
        dat_low_n = dat_low;
        load      = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                if (tx_start) begin
                    state_n = S_INHIBIT;
                    load    = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (cnt == INH_LAST) state_n = S_REQ;
            end
            S_REQ: begin
                if (fall) begin
                    dat_low_n = ~data_q[0];
                    bit_idx_n = 4'd1;
                    state_n   = S_SHIFT;
                end else if (cnt == START_LAST) begin
                    state_n = S_ERROR;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx <= 4'd7) begin
                        dat_low_n = ~data_q[bit_idx[2:0]];
                    end else if (bit_idx == 4'd8) begin
                        dat_low_n = ~parity_q;
                    end else begin
                        // stop bit: release data and wait for the device ACK
                        dat_low_n = 1'b0;
                        state_n   = S_ACK;
                    end
                end else if (cnt == BIT_LAST) begin
                    state_n = S_ERROR;
                end
            end
            S_ACK: begin
                if (fall) begin
                    state_n = dat_sync ? S_ERROR : S_WAIT_IDLE;
                end else if (cnt == BIT_LAST) begin
                    state_n = S_ERROR;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    state_n = S_DONE;
                end else if (fall) begin
                    cnt_n = '0;
                end else if (cnt == BIT_LAST) begin
                    state_n = S_ERROR;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n != state) cnt_n = '0;
    end

    always_comb begin
        ps2_clk_oe = (state == S_INHIBIT);
        ps2_dat_oe = ((state == S_INHIBIT) && (cnt == INH_LAST)) ||
                     (state == S_REQ) ||
                     ((state == S_SHIFT) && dat_low);
        tx_busy    = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
        tx_done    = (state == S_DONE);
        tx_error   = (state == S_ERROR);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx with a behavioural PS/2 device model
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int STO  = 500;
    localparam int BTO  = 200;
    localparam int HALF = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;

    always #5 clock = ~clock;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .BIT_TIMEOUT   (BTO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   done_cnt = 0, err_cnt = 0, err_cyc = 0, release_cyc = 0;
    int   inh_run = 0, dpos_run = 0, last_inh_len = 0, last_inh_dpos = 0;
    logic prev_clk_oe = 1'b0, both_seen = 1'b0;
    logic err_clk_oe = 1'b0, err_dat_oe = 1'b0, err_busy = 1'b0;

    always @(negedge clock) begin
        prev_clk_oe <= ps2_clk_oe;
        if (prev_clk_oe && !ps2_clk_oe) release_cyc <= cyc;
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
            if (ps2_dat_oe && dpos_run == 0) dpos_run <= inh_run + 1;
        end else begin
            if (inh_run != 0) begin
                last_inh_len  <= inh_run;
                last_inh_dpos <= dpos_run;
            end
            inh_run  <= 0;
            dpos_run <= 0;
        end
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt    <= err_cnt + 1;
            err_cyc    <= cyc;
            err_clk_oe <= ps2_clk_oe;
            err_dat_oe <= ps2_dat_oe;
            err_busy   <= tx_busy;
        end
        if (tx_done && tx_error) both_seen <= 1'b1;
    end

    int n_vec = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic device(input int n_edges, input bit ack,
                          output logic [10:0] frame, output int fall4);
        bit rts;
        rts   = 1'b0;
        frame = '1;
        fall4 = 0;
        for (int i = 0; i < 2000 && !rts; i++) begin
            @(negedge clock);
            if (!ps2_clk_oe && ps2_dat_oe && tx_busy) rts = 1'b1;
        end
        check("rts_seen", 32'(rts), 32'd1);
        if (!rts) return;
        repeat ($urandom_range(5, 30)) @(negedge clock);
        frame[0] = ps2_dat_in;
        for (int k = 1; k <= n_edges && k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_dat = 1'b0;
                repeat (HALF / 2) @(negedge clock);
            end
            dev_clk = 1'b0;
            if (k == 4) fall4 = cyc;
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b1;
            if (k <= 10) frame[k] = ps2_dat_in;
            if (k == 11) dev_dat = 1'b1;
            repeat (HALF) @(negedge clock);
        end
    endtask

    task automatic wait_pulse(input int bd, input int be);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == (bd + be) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("pulse_within_budget", 32'(n < 3000), 32'd1);
        repeat (5) @(negedge clock);
    endtask

    task automatic run_full(input logic [7:0] b);
        logic [10:0] fr;
        int          f4, bd, be;
        bd = done_cnt;
        be = err_cnt;
        send(b);
        device(11, 1'b1, fr, f4);
        wait_pulse(bd, be);
        check($sformatf("frame_%02h", b), 32'(fr), 32'(exp_frame(b)));
        check($sformatf("done_%02h", b), 32'(done_cnt - bd), 32'd1);
        check($sformatf("noerr_%02h", b), 32'(err_cnt - be), 32'd0);
    endtask

    logic [10:0] fr;
    int          f4, bd, be;
    logic [7:0]  rb;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        run_full(8'hED);
        check("inhibit_len", 32'(last_inh_len), 32'(INH));
        check("inhibit_dat_pos", 32'(last_inh_dpos), 32'(INH));
        run_full(8'h00);
        run_full(8'h01);
        run_full(8'hFF);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            run_full(rb);
        end

        bd = done_cnt; be = err_cnt;
        send(8'hA5);
        device(11, 1'b0, fr, f4);
        wait_pulse(bd, be);
        check("noack_error", 32'(err_cnt - be), 32'd1);
        check("noack_nodone", 32'(done_cnt - bd), 32'd0);
        check("noack_clk_oe", 32'(err_clk_oe), 32'd0);
        check("noack_dat_oe", 32'(err_dat_oe), 32'd0);
        check("noack_busy", 32'(err_busy), 32'd0);

        bd = done_cnt; be = err_cnt;
        send(8'h3C);
        device(0, 1'b1, fr, f4);
        wait_pulse(bd, be);
        check("start_to_error", 32'(err_cnt - be), 32'd1);
        check("start_to_cycles", 32'(err_cyc - release_cyc), 32'(STO));
        check("start_to_dat_oe", 32'(ps2_dat_oe), 32'd0);

        bd = done_cnt; be = err_cnt;
        send(8'h5A);
        device(4, 1'b1, fr, f4);
        wait_pulse(bd, be);
        check("bit_to_error", 32'(err_cnt - be), 32'd1);
        check("bit_to_nodone", 32'(done_cnt - bd), 32'd0);
        check("bit_to_window", 32'((err_cyc - f4) >= BTO && (err_cyc - f4) <= BTO + 4), 32'd1);

        bd = done_cnt; be = err_cnt;
        send(8'hED);
        fork
            device(11, 1'b1, fr, f4);
            begin
                repeat (300) @(negedge clock);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
                tx_data  = 8'h00;
            end
        join
        wait_pulse(bd, be);
        check("busy_start_frame", 32'(fr), 32'(exp_frame(8'hED)));
        repeat (200) @(negedge clock);
        check("busy_start_one_done", 32'(done_cnt - bd), 32'd1);
        check("busy_start_idle", 32'(tx_busy), 32'd0);

        bd = done_cnt; be = err_cnt;
        send(8'h96);
        device(3, 1'b1, fr, f4);
        reset = 1'b1;
        @(negedge clock);
        check("rst_shift_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_shift_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_shift_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        check("rst_shift_no_pulse", 32'((done_cnt - bd) + (err_cnt - be)), 32'd0);
        run_full(8'h96);

        check("done_error_exclusive", 32'(both_seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
